// File: rtl/ipselector_seg7_mux.sv
// Multiplexed seven-segment display controller with an Avalon-MM slave register file.
// Scans NUM_DIGITS digits with optional hex decode, per-digit blanking and blinking.
module ipselector_seg7_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [7:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_sel
);

   localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

   localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? '1 : '0;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // ctrl bit0 enable, bit1 hex_mode, bit2 blink_en
   logic [2:0]            ctrl_q, ctrl_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic [NUM_DIGITS-1:0] blink_q, blink_d;
   logic [7:0]            digit_q [NUM_DIGITS];
   logic [7:0]            digit_d [NUM_DIGITS];

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FRM_W-1:0]      frm_q, frm_d;
   logic                  phase_q, phase_d;

   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;

   logic                  wr;
   logic                  run;
   logic                  unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata[31:8];

   always_comb begin
      ctrl_d  = ctrl_q;
      blank_d = blank_q;
      blink_d = blink_q;
      digit_d = digit_q;
      if (wr) begin
         case (address)
            4'd0: ctrl_d  = writedata[2:0];
            4'd1: blank_d = writedata[NUM_DIGITS-1:0];
            4'd2: blink_d = writedata[NUM_DIGITS-1:0];
            default: begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (address == 4'(4 + i)) digit_d[i] = writedata[7:0];
               end
            end
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         4'd0: readdata = 32'(ctrl_q);
         4'd1: readdata = 32'(blank_q);
         4'd2: readdata = 32'(blink_q);
         default: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (address == 4'(4 + i)) readdata = 32'(digit_q[i]);
            end
         end
      endcase
   end

   // Counting requires enable both before and after this edge, so a fresh enable
   // gives digit 0 a full dwell and a same-edge disable always clears the counters.
   assign run = ctrl_q[0] & ctrl_d[0];

   always_comb begin
      pre_d   = pre_q;
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      if (!ctrl_d[0]) begin
         pre_d   = '0;
         idx_d   = '0;
         frm_d   = '0;
         phase_d = 1'b0;
      end else if (run) begin
         if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (idx_q == IDX_MAX) begin
               idx_d = '0;
               if (frm_q == FRM_MAX) begin
                  frm_d   = '0;
                  phase_d = ~phase_q;
               end else begin
                  frm_d = frm_q + FRM_W'(1);
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   always_comb begin
      logic [7:0]            cur;
      logic                  blank_bit;
      logic                  blink_bit;
      logic [7:0]            seg_act;
      logic [NUM_DIGITS-1:0] dig_act;
      cur       = 8'h00;
      blank_bit = 1'b0;
      blink_bit = 1'b0;
      dig_act   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur        = digit_q[i];
            blank_bit  = blank_q[i];
            blink_bit  = blink_q[i];
            dig_act[i] = 1'b1;
         end
      end
      seg_act = ctrl_q[1] ? {cur[7], hex7(cur[3:0])} : cur;
      if (blank_bit || (ctrl_q[2] && blink_bit && phase_q)) seg_act = 8'h00;
      if (!ctrl_q[0]) begin
         seg_act = 8'h00;
         dig_act = '0;
      end
      seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
      dig_d = ACTIVE_LOW ? ~dig_act : dig_act;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q  <= '0;
         blank_q <= '0;
         blink_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         seg_q   <= SEG_OFF;
         dig_q   <= DIG_OFF;
      end else begin
         ctrl_q  <= ctrl_d;
         blank_q <= blank_d;
         blink_q <= blink_d;
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign seg_out = seg_q;
   assign dig_sel = dig_q;

endmodule

// File: tb/tb_ipselector_seg7_mux.sv
// Directed bench for ipselector_seg7_mux: 4 digits, 4-cycle dwell, 2-frame blink, active-low.
module tb_ipselector_seg7_mux;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  seg_out;
   logic [3:0]  dig_sel;

   int tests = 0;
   int fails = 0;

   // expected active-low patterns per digit for the scan loops
   logic [3:0] dig_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [7:0] hex_tab [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h08};
   logic [7:0] raw_tab [4] = '{8'hFE, 8'hFF, 8'hAA, 8'h75};

   ipselector_seg7_mux #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .seg_out(seg_out), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; the write lands on the following posedge
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      chk(tag, readdata, exp);
      chipselect = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg", 32'(seg_out), 32'hFF);
      chk("rst_dig", 32'(dig_sel), 32'hF);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 8; a++) rd(4'(a), 32'h0, $sformatf("rst_rd%0d", a));
      rd(4'd9, 32'h0, "rst_rd9");

      // hex scan
      wr(4'd4, 32'h01);
      wr(4'd5, 32'h02);
      wr(4'd6, 32'h03);
      wr(4'd7, 32'h8A);
      wr(4'd0, 32'h3);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk($sformatf("hex_dig c%0d", c), 32'(dig_sel), 32'(dig_tab[c/4]));
         chk($sformatf("hex_seg c%0d", c), 32'(seg_out), 32'(hex_tab[c/4]));
      end

      // raw mode with digit 1 blanked
      wr(4'd0, 32'h0);
      wr(4'd6, 32'h55);
      wr(4'd1, 32'h2);
      wr(4'd0, 32'h1);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk($sformatf("raw_dig c%0d", c), 32'(dig_sel), 32'(dig_tab[c/4]));
         chk($sformatf("raw_seg c%0d", c), 32'(seg_out), 32'(raw_tab[c/4]));
      end

      // blink digit 0, hex mode, DIGIT2 now 55 -> hex 5 = 6D -> ~ = 92
      hex_tab[2] = 8'h92;
      wr(4'd0, 32'h0);
      wr(4'd1, 32'h0);
      wr(4'd2, 32'h1);
      wr(4'd0, 32'h7);
      for (int c = 0; c < 80; c++) begin
         int d;
         logic ph;
         @(negedge clk);
         d  = (c / 4) % 4;
         ph = ((c / 32) % 2) == 1;
         chk($sformatf("blk_dig c%0d", c), 32'(dig_sel), 32'(dig_tab[d]));
         chk($sformatf("blk_seg c%0d", c), 32'(seg_out),
             (d == 0 && ph) ? 32'hFF : 32'(hex_tab[d]));
      end

      // disable while digit 2 is shown, then re-enable
      wr(4'd0, 32'h0);
      wr(4'd0, 32'h7);
      for (int c = 0; c < 9; c++) @(negedge clk);
      chk("dis_pre_dig", 32'(dig_sel), 32'hB);
      wr(4'd0, 32'h0);
      @(negedge clk);
      chk("dis_seg", 32'(seg_out), 32'hFF);
      chk("dis_dig", 32'(dig_sel), 32'hF);
      wr(4'd0, 32'h7);
      @(negedge clk);
      chk("reen_dig", 32'(dig_sel), 32'hE);
      chk("reen_seg", 32'(seg_out), 32'hF9);
      repeat (3) @(negedge clk);
      chk("reen_dwell", 32'(dig_sel), 32'hE);
      @(negedge clk);
      chk("reen_next", 32'(dig_sel), 32'hD);

      // illegal and masked accesses
      wr(4'd3, 32'hFFFF_FFFF);
      wr(4'd15, 32'hFFFF_FFFF);
      rd(4'd3, 32'h0, "ill_rd3");
      rd(4'd15, 32'h0, "ill_rd15");
      rd(4'd8, 32'h0, "ill_rd8");
      rd(4'd12, 32'h0, "ill_rd12");
      rd(4'd0, 32'h7, "ill_ctrl");
      rd(4'd1, 32'h0, "ill_blank");
      rd(4'd2, 32'h1, "ill_blink");
      rd(4'd4, 32'h01, "ill_d0");
      rd(4'd5, 32'h02, "ill_d1");
      rd(4'd6, 32'h55, "ill_d2");
      rd(4'd7, 32'h8A, "ill_d3");
      wr(4'd1, 32'hFFFF_FFFF);
      rd(4'd1, 32'h0000_000F, "blank_mask");

      // asynchronous reset in the middle of a scan
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_seg", 32'(seg_out), 32'hFF);
      chk("mid_rst_dig", 32'(dig_sel), 32'hF);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 8; a++) rd(4'(a), 32'h0, $sformatf("mid_rd%0d", a));
      rd(4'd9, 32'h0, "mid_rd9");
      chk("post_seg", 32'(seg_out), 32'hFF);
      chk("post_dig", 32'(dig_sel), 32'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
